// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_t;

   // ALU operand source select
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_S2 = 2'b01,
      FWD_S3 = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   // Shadow copy of a downstream instruction's register write
   typedef struct packed {
      logic we;
      reg_t rd;
   } slot_t;

   // Writes to r0 are discarded by the register file, so they never hazard
   function automatic logic slot_live(slot_t s);
      return s.we && (s.rd != '0);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard interface: decode instruction in, stall/forward controls out.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import pipe_hazard_ctrl_pkg::*;

   logic             id_valid;
   reg_t             id_rs1;
   reg_t             id_rs2;
   logic             id_use1;
   logic             id_use2;
   logic             id_we;
   reg_t             id_rd;
   logic             flush;
   logic             stall;
   logic             s2_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic             busy;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_we, id_rd, flush,
      input  stall, s2_bubble, fwd_a, fwd_b, stall_cnt, busy
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_we, id_rd, flush,
      output stall, s2_bubble, fwd_a, fwd_b, stall_cnt, busy
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source-operand comparator: flags a match against each live shadow slot.
module hazard_cmp
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic  use_i,
   input  reg_t  rs_i,
   input  slot_t slot2_i,
   input  slot_t slot3_i,
   output logic  hit2_o,
   output logic  hit3_o
);

   // use_i already carries decode-valid gating from the top
   always_comb begin
      hit2_o = use_i && slot_live(slot2_i) && (slot2_i.rd == rs_i);
      hit3_o = use_i && slot_live(slot3_i) && (slot3_i.rd == rs_i);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard controller for a 3-stage pipe: forwards or stalls based on
// shadow copies of the writes held in S2 and S3.
//
//   state | meaning
//   RUN   | no stall was asserted on the previous edge
//   STALL | a stall was asserted on the previous edge (busy=1)
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  hz
);

   slot_t            slot2_q, slot2_d;
   slot_t            slot3_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             hit2_a, hit3_a, hit2_b, hit3_b;
   logic             stall_c;
   logic [1:0]       fwd_a_c, fwd_b_c;

   hazard_cmp u_cmp_a (
      .use_i   (hz.id_valid & hz.id_use1),
      .rs_i    (hz.id_rs1),
      .slot2_i (slot2_q),
      .slot3_i (slot3_q),
      .hit2_o  (hit2_a),
      .hit3_o  (hit3_a)
   );

   hazard_cmp u_cmp_b (
      .use_i   (hz.id_valid & hz.id_use2),
      .rs_i    (hz.id_rs2),
      .slot2_i (slot2_q),
      .slot3_i (slot3_q),
      .hit2_o  (hit2_b),
      .hit3_o  (hit3_b)
   );

   // Resolve hazards: younger slot2 wins when both slots hold the same rd
   always_comb begin
      stall_c = 1'b0;
      fwd_a_c = FWD_RF;
      fwd_b_c = FWD_RF;
      if (FWD_EN != 0) begin
         if (hit2_a)      fwd_a_c = FWD_S2;
         else if (hit3_a) fwd_a_c = FWD_S3;
         if (hit2_b)      fwd_b_c = FWD_S2;
         else if (hit3_b) fwd_b_c = FWD_S3;
      end else begin
         stall_c = hit2_a | hit3_a | hit2_b | hit3_b;
      end
   end

   // Flush and stall both inject a bubble into S2
   always_comb begin
      slot2_d = '0;
      if (hz.id_valid && !stall_c && !hz.flush) begin
         slot2_d = slot_t'{we: hz.id_we, rd: hz.id_rd};
      end
   end

   // State follows the stall seen at the previous edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall_c)  state_d = STALL;
         STALL:   if (!stall_c) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Saturating stall counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Sequential state: shadow slots, FSM and counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot2_q     <= '0;
         slot3_q     <= '0;
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         slot2_q     <= slot2_d;
         slot3_q     <= slot2_q;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall     = stall_c;
   assign hz.s2_bubble = stall_c | hz.flush;
   assign hz.fwd_a     = fwd_a_c;
   assign hz.fwd_b     = fwd_b_c;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.busy      = (state_q == STALL);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, stalling,
// stalling with a 4-bit counter) share one stimulus stream.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, id_we = 1'b0, flush = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

   pipe_hazard_ctrl_if #(.CNT_W(16)) if_f ();
   pipe_hazard_ctrl_if #(.CNT_W(16)) if_s ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  if_c ();

   pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) dut_f (.clk(clk), .rst(rst), .hz(if_f.slave));
   pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(16)) dut_s (.clk(clk), .rst(rst), .hz(if_s.slave));
   pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .hz(if_c.slave));

   assign if_f.id_valid = id_valid; assign if_s.id_valid = id_valid; assign if_c.id_valid = id_valid;
   assign if_f.id_rs1   = id_rs1;   assign if_s.id_rs1   = id_rs1;   assign if_c.id_rs1   = id_rs1;
   assign if_f.id_rs2   = id_rs2;   assign if_s.id_rs2   = id_rs2;   assign if_c.id_rs2   = id_rs2;
   assign if_f.id_use1  = id_use1;  assign if_s.id_use1  = id_use1;  assign if_c.id_use1  = id_use1;
   assign if_f.id_use2  = id_use2;  assign if_s.id_use2  = id_use2;  assign if_c.id_use2  = id_use2;
   assign if_f.id_we    = id_we;    assign if_s.id_we    = id_we;    assign if_c.id_we    = id_we;
   assign if_f.id_rd    = id_rd;    assign if_s.id_rd    = id_rd;    assign if_c.id_rd    = id_rd;
   assign if_f.flush    = flush;    assign if_s.flush    = flush;    assign if_c.flush    = flush;

   logic        obs_stall[3], obs_bub[3], obs_busy[3];
   logic [1:0]  obs_fa[3], obs_fb[3];
   logic [15:0] obs_cnt[3];

   assign obs_stall[0] = if_f.stall;     assign obs_stall[1] = if_s.stall;     assign obs_stall[2] = if_c.stall;
   assign obs_bub[0]   = if_f.s2_bubble; assign obs_bub[1]   = if_s.s2_bubble; assign obs_bub[2]   = if_c.s2_bubble;
   assign obs_busy[0]  = if_f.busy;      assign obs_busy[1]  = if_s.busy;      assign obs_busy[2]  = if_c.busy;
   assign obs_fa[0]    = if_f.fwd_a;     assign obs_fa[1]    = if_s.fwd_a;     assign obs_fa[2]    = if_c.fwd_a;
   assign obs_fb[0]    = if_f.fwd_b;     assign obs_fb[1]    = if_s.fwd_b;     assign obs_fb[2]    = if_c.fwd_b;
   assign obs_cnt[0]   = if_f.stall_cnt;
   assign obs_cnt[1]   = if_s.stall_cnt;
   assign obs_cnt[2]   = {12'd0, if_c.stall_cnt};

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: list of in-flight destination registers, youngest first
   // (0 = nothing that can hazard), a stall tally and last-cycle stall flag.
   int fl[3][2];
   int cnt_m[3];
   bit busy_m[3];
   bit fe_k[3]  = '{1'b1, 1'b0, 1'b0};
   int cmax[3]  = '{65535, 65535, 15};

   function automatic int hit_age(int k, logic u, logic [4:0] rs);
      if (!id_valid || !u || rs == 5'd0) return -1;
      for (int i = 0; i < 2; i++) if (fl[k][i] == int'(rs)) return i;
      return -1;
   endfunction

   function automatic bit m_stall(int k);
      return !fe_k[k] && (hit_age(k, id_use1, id_rs1) >= 0 || hit_age(k, id_use2, id_rs2) >= 0);
   endfunction

   function automatic logic [1:0] m_fwd(int k, int age);
      if (!fe_k[k]) return 2'b00;
      if (age == 0) return 2'b01;
      if (age == 1) return 2'b10;
      return 2'b00;
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 3; k++) begin
         fl[k][0] = 0; fl[k][1] = 0; cnt_m[k] = 0; busy_m[k] = 1'b0;
      end
   endtask

   task automatic m_adv();
      if (rst) begin
         m_clear();
      end else begin
         for (int k = 0; k < 3; k++) begin
            bit st;
            int issue;
            st = m_stall(k);
            issue = (id_valid && !st && !flush && id_we) ? int'(id_rd) : 0;
            fl[k][1] = fl[k][0];
            fl[k][0] = issue;
            if (st && cnt_m[k] < cmax[k]) cnt_m[k]++;
            busy_m[k] = st;
         end
      end
   endtask

   task automatic set_in(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic we, input logic [4:0] rd, input logic fls);
      id_valid = v; id_rs1 = r1; id_use1 = u1; id_rs2 = r2; id_use2 = u2;
      id_we = we; id_rd = rd; flush = fls;
      #1;
   endtask

   task automatic adv();
      m_adv();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      m_clear();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_clear();
      set_in(1, 5'd3, 1, 5'd3, 1, 1, 5'd3, 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (obs_stall[k] !== 1'b0) begin n_bad++; $display("FAIL reset_stall dut%0d got %b want 0", k, obs_stall[k]); end
         n_cmp++; if (obs_fa[k] !== 2'b00 || obs_fb[k] !== 2'b00) begin n_bad++; $display("FAIL reset_fwd dut%0d got %b/%b want 00/00", k, obs_fa[k], obs_fb[k]); end
         n_cmp++; if (obs_bub[k] !== 1'b1) begin n_bad++; $display("FAIL reset_bubble dut%0d got %b want 1", k, obs_bub[k]); end
         n_cmp++; if (obs_cnt[k] !== 16'd0) begin n_bad++; $display("FAIL reset_cnt dut%0d got %0d want 0", k, obs_cnt[k]); end
         n_cmp++; if (obs_busy[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 0", k, obs_busy[k]); end
      end
      rst = 1'b0;
   endtask

   task automatic test_forward();
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 5'd3, 0);
      adv();
      set_in(1, 5'd3, 1, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_fa[0] !== 2'b01) begin n_bad++; $display("FAIL fwd_a_s2 got %b want 01", obs_fa[0]); end
      n_cmp++; if (obs_stall[0] !== 1'b0) begin n_bad++; $display("FAIL fwd_nostall got %b want 0", obs_stall[0]); end
      adv();
      set_in(1, 0, 0, 5'd3, 1, 0, 0, 0);
      n_cmp++; if (obs_fb[0] !== 2'b10) begin n_bad++; $display("FAIL fwd_b_s3 got %b want 10", obs_fb[0]); end
      n_cmp++; if (obs_fa[0] !== 2'b00) begin n_bad++; $display("FAIL fwd_a_unused got %b want 00", obs_fa[0]); end
      adv();
   endtask

   task automatic test_stall();
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 5'd3, 0);
      adv();
      set_in(1, 5'd3, 1, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_stall[1] !== 1'b1 || obs_bub[1] !== 1'b1) begin n_bad++; $display("FAIL stall_c1 got stall=%b bub=%b want 1/1", obs_stall[1], obs_bub[1]); end
      n_cmp++; if (obs_busy[1] !== 1'b0 || obs_fa[1] !== 2'b00) begin n_bad++; $display("FAIL stall_c1_busy got busy=%b fa=%b want 0/00", obs_busy[1], obs_fa[1]); end
      adv();
      n_cmp++; if (obs_stall[1] !== 1'b1 || obs_bub[1] !== 1'b1 || obs_busy[1] !== 1'b1) begin n_bad++; $display("FAIL stall_c2 got stall=%b bub=%b busy=%b want 1/1/1", obs_stall[1], obs_bub[1], obs_busy[1]); end
      adv();
      n_cmp++; if (obs_stall[1] !== 1'b0 || obs_busy[1] !== 1'b1) begin n_bad++; $display("FAIL stall_c3 got stall=%b busy=%b want 0/1", obs_stall[1], obs_busy[1]); end
      n_cmp++; if (obs_cnt[1] !== 16'd2) begin n_bad++; $display("FAIL stall_cnt got %0d want 2", obs_cnt[1]); end
      adv();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_busy[1] !== 1'b0 || obs_cnt[1] !== 16'd2) begin n_bad++; $display("FAIL stall_done got busy=%b cnt=%0d want 0/2", obs_busy[1], obs_cnt[1]); end
   endtask

   task automatic test_r0();
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 5'd0, 0);
      adv();
      set_in(1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
      n_cmp++; if (obs_fa[0] !== 2'b00 || obs_stall[0] !== 1'b0) begin n_bad++; $display("FAIL r0_fwd got fa=%b stall=%b want 00/0", obs_fa[0], obs_stall[0]); end
      n_cmp++; if (obs_stall[1] !== 1'b0) begin n_bad++; $display("FAIL r0_stall got %b want 0", obs_stall[1]); end
      adv();
   endtask

   task automatic test_both_slots();
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 5'd5, 0);
      adv();
      set_in(1, 0, 0, 0, 0, 1, 5'd5, 0);
      adv();
      set_in(1, 5'd5, 1, 5'd9, 1, 0, 0, 0);
      n_cmp++; if (obs_fa[0] !== 2'b01 || obs_fb[0] !== 2'b00) begin n_bad++; $display("FAIL both_younger got fa=%b fb=%b want 01/00", obs_fa[0], obs_fb[0]); end
      n_cmp++; if (obs_stall[1] !== 1'b1) begin n_bad++; $display("FAIL both_stall got %b want 1", obs_stall[1]); end
      adv();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_in(1, 0, 0, 0, 0, 1, 5'd3, 0);
      adv();
      set_in(1, 5'd3, 1, 0, 0, 0, 0, 0);
      adv();
      n_cmp++; if (obs_stall[1] !== 1'b1 || obs_busy[1] !== 1'b1) begin n_bad++; $display("FAIL mid_pre got stall=%b busy=%b want 1/1", obs_stall[1], obs_busy[1]); end
      rst = 1'b1;
      m_clear();
      #1;
      n_cmp++; if (obs_stall[1] !== 1'b0 || obs_busy[1] !== 1'b0 || obs_cnt[1] !== 16'd0) begin n_bad++; $display("FAIL mid_rst got stall=%b busy=%b cnt=%0d want 0/0/0", obs_stall[1], obs_busy[1], obs_cnt[1]); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      set_in(1, 5'd3, 1, 0, 0, 1, 5'd7, 0);
      n_cmp++; if (obs_stall[1] !== 1'b0 || obs_busy[1] !== 1'b0) begin n_bad++; $display("FAIL mid_after got stall=%b busy=%b want 0/0", obs_stall[1], obs_busy[1]); end
      adv();
      set_in(1, 5'd7, 1, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_stall[1] !== 1'b1 || obs_cnt[1] !== 16'd0) begin n_bad++; $display("FAIL mid_issued got stall=%b cnt=%0d want 1/0", obs_stall[1], obs_cnt[1]); end
      adv();
   endtask

   task automatic test_saturate();
      int nst;
      nst = 0;
      do_reset();
      for (int i = 0; i < 100 && nst < 20; i++) begin
         set_in(1, 5'd3, 1, 0, 0, 1, 5'd3, 0);
         if (m_stall(2)) nst++;
         adv();
      end
      n_cmp++; if (nst != 20) begin n_bad++; $display("FAIL sat_budget got %0d stalls want 20", nst); end
      n_cmp++; if (obs_cnt[2] !== 16'd15) begin n_bad++; $display("FAIL sat_cnt4 got %0d want 15", obs_cnt[2]); end
      n_cmp++; if (obs_cnt[1] !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16 got %0d want 20", obs_cnt[1]); end
      for (int i = 0; i < 6; i++) begin
         set_in(1, 5'd3, 1, 0, 0, 1, 5'd3, 0);
         adv();
      end
      n_cmp++; if (obs_cnt[2] !== 16'd15) begin n_bad++; $display("FAIL sat_hold got %0d want 15", obs_cnt[2]); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            m_clear();
         end else begin
            rst = 1'b0;
         end
         set_in(($urandom_range(0, 9) < 8),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 15));
         for (int k = 0; k < 3; k++) begin
            bit         es;
            logic [1:0] ea, eb;
            es = m_stall(k);
            ea = m_fwd(k, hit_age(k, id_use1, id_rs1));
            eb = m_fwd(k, hit_age(k, id_use2, id_rs2));
            n_cmp++; if (obs_stall[k] !== es) begin n_bad++; $display("FAIL rnd_stall dut%0d cyc%0d got %b want %b", k, n, obs_stall[k], es); end
            n_cmp++; if (obs_bub[k] !== (es | flush)) begin n_bad++; $display("FAIL rnd_bubble dut%0d cyc%0d got %b want %b", k, n, obs_bub[k], es | flush); end
            n_cmp++; if (obs_fa[k] !== ea || obs_fb[k] !== eb) begin n_bad++; $display("FAIL rnd_fwd dut%0d cyc%0d got %b/%b want %b/%b", k, n, obs_fa[k], obs_fb[k], ea, eb); end
            n_cmp++; if (obs_cnt[k] !== 16'(cnt_m[k])) begin n_bad++; $display("FAIL rnd_cnt dut%0d cyc%0d got %0d want %0d", k, n, obs_cnt[k], cnt_m[k]); end
            n_cmp++; if (obs_busy[k] !== busy_m[k]) begin n_bad++; $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", k, n, obs_busy[k], busy_m[k]); end
         end
         adv();
      end
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_clear();
      test_reset();
      test_forward();
      test_stall();
      test_r0();
      test_both_slots();
      test_reset_mid_stall();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
